// File: rtl/eight_bit_adder_pkg.sv
// Shared types and widths for the registered ripple-carry adder.
// The optional EIGHT_BIT_ADDER_OVF_EN build adds a signed-overflow output to eight_bit_adder.
package eight_bit_adder_pkg;

    localparam int unsigned ADDER_WIDTH = 8;

    typedef logic [ADDER_WIDTH-1:0] operand_t;
    typedef logic [ADDER_WIDTH:0]   sum_t;

endpackage

// File: rtl/eight_bit_adder_full_adder_cell.sv
// One-bit full adder: the ripple-chain leaf cell of eight_bit_adder.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/eight_bit_adder.sv
// Registered unsigned adder built from a ripple chain of full_adder_cell, one output stage.
// Define EIGHT_BIT_ADDER_OVF_EN to add the registered two's-complement overflow output.
module eight_bit_adder
    import eight_bit_adder_pkg::*;
#(
    parameter int unsigned WIDTH = ADDER_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             carry_out,
`ifdef EIGHT_BIT_ADDER_OVF_EN
    output logic             overflow,
`endif
    output logic             out_valid
);

    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] r_y;
    logic             r_carry;
    logic             r_valid;

    assign w_carry[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_cell u_cell (
            .a   (a[i]),
            .b   (b[i]),
            .cin (w_carry[i]),
            .s   (w_sum[i]),
            .cout(w_carry[i+1])
        );
    end

    // Result registers hold their value when no new operand arrives.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_y     <= '0;
            r_carry <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_y     <= w_sum;
                r_carry <= w_carry[WIDTH];
            end
        end
    end

    assign y         = r_y;
    assign carry_out = r_carry;
    assign out_valid = r_valid;

`ifdef EIGHT_BIT_ADDER_OVF_EN
    logic w_ovf;
    logic r_ovf;

    // Carry into and out of the sign bit disagree exactly on signed overflow.
    assign w_ovf = w_carry[WIDTH] ^ w_carry[WIDTH-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (in_valid) begin
            r_ovf <= w_ovf;
        end
    end

    assign overflow = r_ovf;
`endif

endmodule

// File: tb/tb_eight_bit_adder.sv
// Self-checking bench for eight_bit_adder: vector table, exhaustive sweep, mid-stream reset.
// Checks overflow too when EIGHT_BIT_ADDER_OVF_EN is defined.
module tb_eight_bit_adder;
    import eight_bit_adder_pkg::*;

    typedef struct {
        logic     rst_n;
        logic     vld;
        operand_t a;
        operand_t b;
        operand_t exp_y;
        logic     exp_c;
        logic     exp_v;
        logic     exp_o;
    } vec_t;

    typedef struct {
        operand_t y;
        logic     c;
        logic     v;
        logic     o;
        string    name;
    } exp_t;

    logic     clk;
    logic     rst_n;
    logic     in_valid;
    operand_t a;
    operand_t b;
    operand_t y;
    logic     carry_out;
    logic     out_valid;
    logic     overflow;

    int checks;
    int failures;
    exp_t sb[$];

    eight_bit_adder #(
        .WIDTH(ADDER_WIDTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .y        (y),
        .carry_out(carry_out),
`ifdef EIGHT_BIT_ADDER_OVF_EN
        .overflow (overflow),
`endif
        .out_valid(out_valid)
    );

`ifndef EIGHT_BIT_ADDER_OVF_EN
    assign overflow = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle, queue the expected result, then pop and compare after the edge.
    task automatic step(input logic r, input logic v, input operand_t ia, input operand_t ib,
                        input operand_t ey, input logic ec, input logic ev, input logic eo,
                        input string name);
        exp_t e;
        rst_n    = r;
        in_valid = v;
        a        = ia;
        b        = ib;
        e.y = ey; e.c = ec; e.v = ev; e.o = eo; e.name = name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
`ifdef EIGHT_BIT_ADDER_OVF_EN
        if (y !== e.y || carry_out !== e.c || out_valid !== e.v || overflow !== e.o) begin
`else
        if (y !== e.y || carry_out !== e.c || out_valid !== e.v) begin
`endif
            failures++;
            $display("FAIL %s a=%0d b=%0d: got y=%0d c=%b v=%b o=%b, want y=%0d c=%b v=%b o=%b",
                     e.name, ia, ib, y, carry_out, out_valid, overflow,
                     e.y, e.c, e.v, e.o);
        end
    endtask

    initial begin
        vec_t vecs[$];
        logic [8:0] s;
        logic       ovf;
        operand_t   ya;
        operand_t   yb;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;

        //             rst   vld   a    b    y    c     v     o
        vecs.push_back('{1'b0, 1'b1, 5,   3,   0,   1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 5,   3,   0,   1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 5,   3,   8,   1'b0, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 255, 1,   0,   1'b1, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 200, 100, 44,  1'b1, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 255, 255, 254, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 10,  20,  30,  1'b0, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 99,  99,  30,  1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 99,  99,  30,  1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 99,  99,  30,  1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 127, 1,   128, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 128, 255, 127, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 64,  63,  127, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 128, 128, 0,   1'b1, 1'b1, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 7,   7,   0,   1'b1, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 100, 27,  127, 1'b0, 1'b1, 1'b0});

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst_n, vecs[i].vld, vecs[i].a, vecs[i].b, vecs[i].exp_y,
                 vecs[i].exp_c, vecs[i].exp_v, vecs[i].exp_o, $sformatf("vec%0d", i));
        end

        // Exhaustive back-to-back sweep.
        for (int i = 0; i < 256; i++) begin
            for (int j = 0; j < 256; j++) begin
                ya  = operand_t'(i);
                yb  = operand_t'(j);
                s   = 9'(i + j);
                ovf = (ya[7] == yb[7]) && (s[7] != ya[7]);
                step(1'b1, 1'b1, ya, yb, s[7:0], s[8], 1'b1, ovf, "sweep");
            end
        end

        // Mid-stream reset: the i=5 operand is dropped.
        for (int i = 0; i < 10; i++) begin
            ya = operand_t'(i);
            if (i == 5) begin
                step(1'b0, 1'b1, ya, ya, 0, 1'b0, 1'b0, 1'b0, "midreset");
            end else begin
                s = 9'(2 * i);
                step(1'b1, 1'b1, ya, ya, s[7:0], s[8], 1'b1, 1'b0, "stream");
            end
        end

        // Reset raised mid-cycle must not act before the next edge.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (y !== 8'd18 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL async_reset: got y=%0d v=%b, want y=18 v=1", y, out_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (y !== 8'd0 || carry_out !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL sync_reset: got y=%0d c=%b v=%b, want y=0 c=0 v=0",
                     y, carry_out, out_valid);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/eight_bit_adder.md
Name: eight_bit_adder

Overview:
- Registered 8-bit unsigned adder: y = a + b, with a carry-out.
- Structured as a ripple-carry chain of one-bit full-adder cells, followed by one output register stage.
- Datapath leaf block with a simple valid qualifier; no backpressure.

Parameters:
- WIDTH, 8, operand and sum width in bits. Must be at least 1. All behaviour below is stated for the default of 8.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  a and b are valid this cycle.
- a  input  WIDTH  unsigned operand A.
- b  input  WIDTH  unsigned operand B.
- y  output  WIDTH  registered sum, bits [WIDTH-1:0] of a+b.
- carry_out  output  1  registered carry, bit WIDTH of a+b.
- out_valid  output  1  y and carry_out hold a new result this cycle.

Behaviour:
- Reset:
  - rst_n=0 at a rising clk edge forces y=0, carry_out=0, out_valid=0.
  - Reset is synchronous: asserting rst_n mid-cycle has no effect until the next edge.
  - Reset dominates in_valid. An operand presented in the same cycle as reset is discarded.
- Arithmetic:
  - Combinational sum {carry, sum} = a + b, computed as an unsigned (WIDTH+1)-bit value.
  - No carry-in; bit 0 cell carry-in is tied to 0.
  - Ripple chain: cell i takes a[i], b[i] and c[i], and produces s[i] and c[i+1]. carry_out comes from c[WIDTH].
  - Wrap-around: 255+1 gives y=0, carry_out=1. 255+255 gives y=254, carry_out=1.
- Latency and handshake:
  - If in_valid=1 at edge N (not in reset): y and carry_out update with that sum, and out_valid=1 after edge N.
  - If in_valid=0 at edge N: y and carry_out hold their previous values, and out_valid=0 after edge N.
  - Fixed 1-cycle latency. Throughput is one result per cycle. Back-to-back valid inputs give back-to-back results.
  - No ready signal; the block always accepts.
- Inputs are not registered; the combinational chain is inside the single register stage.
- No X propagation requirement beyond standard two-state simulation. Outputs are never X after the first reset edge.

Optional Feature:
- Macro: EIGHT_BIT_ADDER_OVF_EN.
- Defined:
  - Adds output port overflow (output, 1 bit), registered with the same timing and enable as y.
  - overflow = c[WIDTH] XOR c[WIDTH-1], i.e. two's-complement signed overflow of a+b.
  - Reset value of overflow is 0.
  - Examples: 127+1 gives overflow=1; 128+128 gives overflow=1, y=0, carry_out=1; 100+27 gives overflow=0.
- Undefined:
  - Port overflow does not exist.
  - Behaviour of all other ports is identical to the defined case.

Decomposition:
- Shared package eight_bit_adder_pkg:
  - Localparam ADDER_WIDTH = 8.
  - Typedef operand_t as logic [ADDER_WIDTH-1:0].
  - Typedef sum_t as logic [ADDER_WIDTH:0].
- One sub-module: full_adder_cell, ports a, b, cin, s, cout.
  - s = a^b^cin; cout = majority(a,b,cin).
  - Instantiated WIDTH times via a generate loop inside eight_bit_adder.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1, a=5, b=3 -> y=0, carry_out=0, out_valid=0. Release rst_n -> next edge gives y=8, carry_out=0, out_valid=1.
- Wrap/carry: a=255, b=1 -> one cycle later y=0, carry_out=1. Then a=200, b=100 -> y=44, carry_out=1. Then a=255, b=255 -> y=254, carry_out=1.
- Hold: send a=10, b=20 with in_valid=1, then in_valid=0 for 3 cycles with a=99, b=99 -> y stays 30, out_valid=1 then 0,0,0.
- Exhaustive sweep: all 65536 (a,b) pairs back-to-back with in_valid=1 -> each result, one cycle later, equals {carry_out,y} = a+b as a 9-bit value, with out_valid=1 every cycle.
- Mid-stream reset: stream a=i, b=i for i=0..9; drop rst_n for one edge at i=5 -> outputs 0/0/0 after that edge, the i=5 operand is lost, and the stream resumes correctly from i=6.
- With EIGHT_BIT_ADDER_OVF_EN: a=127, b=1 -> overflow=1, y=128, carry_out=0. a=128, b=255 -> overflow=1, y=127, carry_out=1. a=64, b=63 -> overflow=0.
